// File: rtl/s_rbs12_seq_pkg.sv
// Shared types and sizing helpers for the multi-cycle arithmetic blocks.
package arith_seq_pkg;

  localparam int DEF_N     = 12;
  localparam int DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunks(input int n, input int chunk);
    return n / chunk;
  endfunction

  // One spare bit so the chunk index never wraps while counting chunks.
  function automatic int idx_width(input int n, input int chunk);
    return $clog2(n / chunk) + 1;
  endfunction

endpackage

// File: rtl/s_rbs12_seq_if.sv
// Operand/result handshake bundle for the sequential subtractor.
interface s_rbs12_seq_if #(
  parameter int N = arith_seq_pkg::DEF_N
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   diff;
  logic         busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, busy
  );
endinterface

// File: rtl/s_rbs12_seq_fs_chunk.sv
// Combinational ripple-borrow subtractor over one chunk: d = a - b - bin.
module fs_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] d,
  output logic         bout
);

  logic br;

  always_comb begin
    br = bin;
    d  = '0;
    for (int i = 0; i < W; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/s_rbs12_seq.sv
// Signed subtractor producing an overflow-free (N+1)-bit a - b, CHUNK bits per clock.
module s_rbs12_seq
  import arith_seq_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic          clk,
  input  logic          rst_n,
  s_rbs12_seq_if.slave  bus
);

  localparam int NCH   = nchunks(N, CHUNK);
  localparam int IDX_W = idx_width(N, CHUNK);

  generate
    if (N < 2 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_param
      $error("s_rbs12_seq: CHUNK must divide N, with 1 <= CHUNK <= N and N >= 2");
    end
  endgenerate

  state_t             state_q;
  logic [N-1:0]       a_q;
  logic [N-1:0]       b_q;
  logic               borrow_q;
  logic [IDX_W-1:0]   idx_q;
  logic [N:0]         diff_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [CHUNK-1:0]   a_parts [NCH];
  logic [CHUNK-1:0]   b_parts [NCH];
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   d_chunk;
  logic               bout_chunk;
  logic               last_chunk;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_parts
      assign a_parts[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_parts[gi] = b_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  // Compare-based mux keeps the wider index from addressing past the last chunk.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_chunk = a_parts[k];
        b_chunk = b_parts[k];
      end
    end
  end

  assign last_chunk = (idx_q == IDX_W'(NCH - 1));

  fs_chunk #(.W(CHUNK)) u_fs_chunk (
    .a    (a_chunk),
    .b    (b_chunk),
    .bin  (borrow_q),
    .d    (d_chunk),
    .bout (bout_chunk)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      idx_q       <= '0;
      diff_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            borrow_q   <= 1'b0;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          for (int k = 0; k < NCH; k++) begin
            if (idx_q == IDX_W'(k)) begin
              diff_q[k*CHUNK +: CHUNK] <= d_chunk;
            end
          end
          borrow_q <= bout_chunk;
          idx_q    <= idx_q + IDX_W'(1);
          if (last_chunk) begin
            // Sign bit of the widened result: sign(a) - sign(b) - borrow into bit N.
            diff_q[N]   <= a_q[N-1] ^ b_q[N-1] ^ bout_chunk;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_s_rbs12_seq.sv
// Directed checks of s_rbs12_seq: latency, extremes, borrow ripple, backpressure, reset abort.
module tb_s_rbs12_seq;
  import arith_seq_pkg::*;

  localparam int N     = 12;
  localparam int CHUNK = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  s_rbs12_seq_if #(.N(N)) bus ();

  s_rbs12_seq #(.N(N), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after the accepting edge; checks out_valid arrives exactly 3 edges later.
  task automatic wait_result(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.out_valid && cyc < 20);
    check({tag, "_latency"}, cyc, 3);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N:0] exp);
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_in_ready_busy"}, {31'd0, bus.in_ready}, 0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 1);
    wait_result(tag);
    check({tag, "_diff"}, {19'd0, bus.diff}, {19'd0, exp});
    $display("op %s: a=%03h b=%03h diff=%04h expect=%04h", tag, a, b, bus.diff, exp);
    @(posedge clk);
    #1;
    check({tag, "_out_valid_clr"}, {31'd0, bus.out_valid}, 0);
    check({tag, "_in_ready_back"}, {31'd0, bus.in_ready}, 1);
  endtask

  typedef struct {
    string        tag;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N:0]   exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"basic",   12'h005, 12'h003, 13'h0002};
    vecs[1] = '{"mostneg", 12'h800, 12'h7FF, 13'h1001};
    vecs[2] = '{"mostpos", 12'h7FF, 12'h800, 13'h0FFF};
    vecs[3] = '{"zero",    12'h000, 12'h000, 13'h0000};
    vecs[4] = '{"xborrow", 12'h100, 12'h001, 13'h00FF};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
    #12;
    check("rst_in_ready",  {31'd0, bus.in_ready},  1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_busy",      {31'd0, bus.busy},      0);
    check("rst_diff",      {19'd0, bus.diff},      0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Backpressure with in_valid held and operands changing behind the accepted pair.
    bus.a         = 12'h123;
    bus.b         = 12'h456;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.a = 12'h9AB;
    bus.b = 12'h0CD;
    wait_result("bp1");
    check("bp1_diff", {19'd0, bus.diff}, 32'h1CCD);
    $display("op bp1: a=123 b=456 diff=%04h expect=1ccd", bus.diff);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", {31'd0, bus.out_valid}, 1);
      check("bp_hold_diff",  {19'd0, bus.diff},      32'h1CCD);
      check("bp_hold_ready", {31'd0, bus.in_ready},  0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", {31'd0, bus.out_valid}, 0);
    check("bp_release_ready", {31'd0, bus.in_ready},  1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("bp2_accepted", {31'd0, bus.busy}, 1);
    wait_result("bp2");
    check("bp2_diff", {19'd0, bus.diff}, 32'h18DE);
    $display("op bp2: a=9ab b=0cd diff=%04h expect=18de", bus.diff);
    @(posedge clk);
    #1;

    // Asynchronous abort during the second BUSY cycle.
    bus.a        = 12'h123;
    bus.b        = 12'h456;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready",  {31'd0, bus.in_ready},  1);
    check("abort_out_valid", {31'd0, bus.out_valid}, 0);
    check("abort_busy",      {31'd0, bus.busy},      0);
    check("abort_diff",      {19'd0, bus.diff},      0);
    $display("op abort: reset asserted mid-computation");
    @(posedge clk);
    #1;
    check("abort_hold_valid", {31'd0, bus.out_valid}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op("after_rst", 12'hFFF, 12'h001, 13'h1FFE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
